// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the register file's single write port between the pipeline writeback
// stage and a long-latency result source. Writeback always wins. Long-latency
// results wait in an in-order circular buffer and drain on idle write-port
// cycles. Entries are squashed when a younger writeback hits the same rd.
// The block also answers pending-write lookups for the hazard unit, and raises
// a registered stall request when the buffer head is starved.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   wb_valid/rd/data      pipeline writeback request
//   lu_valid/rd/data      long-latency result offer; lu_ready = buffer has room
//   rs1_q, rs2_q          hazard query addresses -> pend_hit1, pend_hit2
//   rf_we/waddr/wdata     register file write port
//   stall_req             registered request for a writeback bubble
//   pending_count         occupied buffer entries, squashed ones included
module regfile_write_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_rd,
    input  logic [31:0]                wb_data,
    input  logic                       lu_valid,
    input  logic [4:0]                 lu_rd,
    input  logic [31:0]                lu_data,
    output logic                       lu_ready,
    input  logic [4:0]                 rs1_q,
    input  logic [4:0]                 rs2_q,
    output logic                       pend_hit1,
    output logic                       pend_hit2,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic                       stall_req,
    output logic [$clog2(DEPTH):0]     pending_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [SW-1:0] LimitC = SW'(STARVE_LIMIT);

    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]       ent_rd_q   [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [SW-1:0]    starve_q, starve_d;
    logic             stall_q, stall_d;

    logic wb_win;     // writeback owns the port this cycle
    logic nonempty;
    logic head_vld;
    logic pop;        // head leaves the buffer (written or silently dropped)
    logic store;      // accepted result that is actually kept
    logic blocked;    // valid head lost the port to writeback

    always_comb begin
        wb_win   = wb_valid && (wb_rd != 5'd0);
        nonempty = (count_q != '0);
        head_vld = nonempty && vld_q[head_q];
        pop      = !wb_win && nonempty;
        lu_ready = !reset && (count_q < DepthC);
        store    = lu_valid && lu_ready && (lu_rd != 5'd0);
        blocked  = wb_win && head_vld;
    end

    // Write port mux: writeback, else valid head, else idle.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!reset) begin
            if (wb_win) begin
                rf_we    = 1'b1;
                rf_waddr = wb_rd;
                rf_wdata = wb_data;
            end else if (head_vld) begin
                rf_we    = 1'b1;
                rf_waddr = ent_rd_q[head_q];
                rf_wdata = ent_data_q[head_q];
            end
        end
    end

    // Hazard lookups see only registered state.
    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (ent_rd_q[i] == rs1_q)) pend_hit1 = 1'b1;
            if (vld_q[i] && (ent_rd_q[i] == rs2_q)) pend_hit2 = 1'b1;
        end
        if (reset || (rs1_q == 5'd0)) pend_hit1 = 1'b0;
        if (reset || (rs2_q == 5'd0)) pend_hit2 = 1'b0;
    end

    always_comb begin
        head_d  = pop ? head_q + AW'(1) : head_q;
        tail_d  = store ? tail_q + AW'(1) : tail_q;
        count_d = count_q;
        if (store && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!store && pop) begin
            count_d = count_q - CW'(1);
        end

        // Younger writeback squashes older buffered writes to the same rd.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i] && !(wb_win && (ent_rd_q[i] == wb_rd));
        end
        if (pop) vld_d[head_q] = 1'b0;
        // Slot at tail is never the head being popped: store needs room, pop needs data.
        if (store) vld_d[tail_q] = !(wb_win && (wb_rd == lu_rd));

        starve_d = starve_q;
        if (pop || (count_d == '0)) begin
            starve_d = '0;
        end else if (blocked && (starve_q != LimitC)) begin
            starve_d = starve_q + SW'(1);
        end

        stall_d = stall_q;
        if (pop) begin
            stall_d = 1'b0;
        end else if (starve_d == LimitC) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Payload needs no reset; the valid bits and count qualify it.
    always_ff @(posedge clk) begin
        if (store) begin
            ent_rd_q[tail_q]   <= lu_rd;
            ent_data_q[tail_q] <= lu_data;
        end
    end

    assign stall_req     = stall_q;
    assign pending_count = count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid, lu_valid;
    logic [4:0]  wb_rd, lu_rd, rs1_q, rs2_q;
    logic [31:0] wb_data, lu_data;
    logic        lu_ready, pend_hit1, pend_hit2, rf_we, stall_req;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  pending_count;

    int tests = 0;
    int fails = 0;

    regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .rs1_q(rs1_q), .rs2_q(rs2_q), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req), .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    // Reference model: in-order queue of pending results plus a starvation count.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          v;
    } ent_t;

    ent_t mq[$];
    int   m_starve;
    bit   m_stall;

    function automatic bit m_wbw();
        return wb_valid && (wb_rd != 5'd0);
    endfunction

    function automatic bit m_head_v();
        return (mq.size() > 0) && mq[0].v;
    endfunction

    function automatic bit m_hit(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].v && (mq[i].rd == rs)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_starve = 0;
        m_stall  = 1'b0;
    endtask

    task automatic model_edge();
        bit   wbw, pop, blocked, acc;
        ent_t e;
        if (reset) begin
            model_clear();
            return;
        end
        wbw     = m_wbw();
        pop     = !wbw && (mq.size() > 0);
        blocked = wbw && m_head_v();
        acc     = lu_valid && (mq.size() < DEPTH) && (lu_rd != 5'd0);
        if (pop) void'(mq.pop_front());
        if (wbw) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].rd == wb_rd) begin
                    e = mq[i];
                    e.v = 1'b0;
                    mq[i] = e;
                end
            end
        end
        if (acc) begin
            e.rd   = lu_rd;
            e.data = lu_data;
            e.v    = !(wbw && (wb_rd == lu_rd));
            mq.push_back(e);
        end
        if (pop || (mq.size() == 0)) m_starve = 0;
        else if (blocked && (m_starve < LIMIT)) m_starve++;
        if (pop) m_stall = 1'b0;
        else if (m_starve >= LIMIT) m_stall = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        rs1_q = 0; rs2_q = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        lu_valid = 1'b1; lu_rd = 5'd5; wb_valid = 1'b1; wb_rd = 5'd4;
        @(posedge clk); #1;
        model_clear();
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", rf_we); end
        tests++; if (lu_ready !== 1'b0) begin fails++; $display("FAIL reset_lu_ready: got %b want 0", lu_ready); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        tests++; if (pending_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", pending_count); end
        idle();
        reset = 1'b0;
        #1;
        tests++; if (lu_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", lu_ready); end
    endtask

    task automatic test_basic();
        idle();
        lu_valid = 1; lu_rd = 5'd5; lu_data = 32'hDEAD_BEEF;
        #1;
        tests++; if (lu_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b want 1", lu_ready); end
        tick();
        idle(); #1;
        tests++; if (pending_count !== 3'd1) begin fails++; $display("FAIL basic_count1: got %0d want 1", pending_count); end
        tests++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            fails++; $display("FAIL basic_write: got we=%b a=%0d d=%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        tests++; if (pending_count !== 3'd0) begin fails++; $display("FAIL basic_count0: got %0d want 0", pending_count); end
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL basic_idle_we: got %b want 0", rf_we); end
    endtask

    task automatic test_fill_drain();
        idle();
        wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h33;
        for (int k = 0; k < 4; k++) begin
            lu_valid = 1; lu_rd = 5'(6 + k); lu_data = 32'h100 + k;
            #1;
            tests++; if (lu_ready !== 1'b1) begin fails++; $display("FAIL fill_ready%0d: got %b want 1", k, lu_ready); end
            tests++; if (rf_waddr !== 5'd3) begin fails++; $display("FAIL fill_wb_wins%0d: got %0d want 3", k, rf_waddr); end
            tick();
        end
        lu_valid = 1; lu_rd = 5'd11; lu_data = 32'hBAD;
        #1;
        tests++; if (lu_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", lu_ready); end
        tests++; if (pending_count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d want 4", pending_count); end
        tick();
        tests++; if (pending_count !== 3'd4) begin fails++; $display("FAIL held_off_count: got %0d want 4", pending_count); end
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(6 + k), 32'h100 + k}) begin
                fails++; $display("FAIL drain%0d: got we=%b a=%0d d=%h want 1/%0d/%h", k, rf_we, rf_waddr, rf_wdata, 6 + k, 32'h100 + k);
            end
            tick();
        end
        tests++; if (pending_count !== 3'd0) begin fails++; $display("FAIL drain_count: got %0d want 0", pending_count); end
    endtask

    task automatic test_squash();
        idle();
        wb_valid = 1; wb_rd = 5'd7; wb_data = 32'h7;
        lu_valid = 1; lu_rd = 5'd10; lu_data = 32'hAAAA_0000;
        tick();
        lu_valid = 0; wb_rd = 5'd10; wb_data = 32'h1; rs1_q = 5'd10;
        #1;
        tests++; if (pend_hit1 !== 1'b1) begin fails++; $display("FAIL squash_hit_before: got %b want 1", pend_hit1); end
        tests++; if ({rf_waddr, rf_wdata} !== {5'd10, 32'h1}) begin
            fails++; $display("FAIL squash_wb: got a=%0d d=%h want 10/1", rf_waddr, rf_wdata);
        end
        tick();
        wb_valid = 0; wb_rd = 0;
        #1;
        tests++; if (pend_hit1 !== 1'b0) begin fails++; $display("FAIL squash_hit_after: got %b want 0", pend_hit1); end
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL squash_pop_we: got %b want 0", rf_we); end
        tests++; if (pending_count !== 3'd1) begin fails++; $display("FAIL squash_count1: got %0d want 1", pending_count); end
        tick();
        tests++; if (pending_count !== 3'd0) begin fails++; $display("FAIL squash_count0: got %0d want 0", pending_count); end
    endtask

    task automatic test_x0();
        idle();
        lu_valid = 1; lu_rd = 5'd0; lu_data = 32'h1234;
        #1;
        tests++; if (lu_ready !== 1'b1) begin fails++; $display("FAIL x0_ready: got %b want 1", lu_ready); end
        tick();
        idle(); #1;
        tests++; if (pending_count !== 3'd0) begin fails++; $display("FAIL x0_count: got %0d want 0", pending_count); end
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL x0_we: got %b want 0", rf_we); end
        tests++; if (pend_hit1 !== 1'b0) begin fails++; $display("FAIL x0_hit: got %b want 0", pend_hit1); end
    endtask

    task automatic test_starve();
        idle();
        wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h44;
        lu_valid = 1; lu_rd = 5'd12; lu_data = 32'hC0FFEE;
        tick();
        lu_valid = 0;
        for (int c = 0; c < LIMIT; c++) begin
            #1;
            tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL starve_early%0d: got %b want 0", c, stall_req); end
            tick();
        end
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL starve_rise: got %b want 1", stall_req); end
        idle(); #1;
        tests++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'hC0FFEE}) begin
            fails++; $display("FAIL starve_head_write: got we=%b a=%0d d=%h want 1/12/c0ffee", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL starve_fall: got %b want 0", stall_req); end
    endtask

    task automatic test_reset_mid_drain();
        idle();
        wb_valid = 1; wb_rd = 5'd2; wb_data = 32'h22;
        for (int k = 0; k < 3; k++) begin
            lu_valid = 1; lu_rd = 5'(13 + k); lu_data = 32'h500 + k;
            tick();
        end
        lu_valid = 0;
        for (int c = 0; c < 9; c++) tick();
        tests++; if ({stall_req, pending_count} !== {1'b1, 3'd3}) begin
            fails++; $display("FAIL mid_pre: got stall=%b cnt=%0d want 1/3", stall_req, pending_count);
        end
        wb_valid = 0; lu_valid = 1; lu_rd = 5'd20;
        #1;
        tests++; if ({rf_we, rf_waddr} !== {1'b1, 5'd13}) begin
            fails++; $display("FAIL mid_drain: got we=%b a=%0d want 1/13", rf_we, rf_waddr);
        end
        reset = 1'b1;
        model_clear();
        #1;
        tests++; if ({rf_we, lu_ready, stall_req} !== 3'b000) begin
            fails++; $display("FAIL mid_reset: got we=%b rdy=%b stall=%b want 0/0/0", rf_we, lu_ready, stall_req);
        end
        tick();
        reset = 1'b0;
        idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if ({rf_we, pending_count} !== {1'b0, 3'd0}) begin
                fails++; $display("FAIL mid_after%0d: got we=%b cnt=%0d want 0/0", c, rf_we, pending_count);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit          e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        int          wbpct;
        for (int cyc = 0; cyc < 800; cyc++) begin
            wbpct    = ((cyc / 100) % 2 == 1) ? 92 : 40;
            wb_valid = ($urandom_range(0, 99) < wbpct);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            lu_valid = ($urandom_range(0, 99) < 55);
            lu_rd    = 5'($urandom_range(0, 7));
            lu_data  = $urandom;
            rs1_q    = 5'($urandom_range(0, 7));
            rs2_q    = 5'($urandom_range(0, 7));
            #1;
            e_we = 1'b0; e_a = 5'd0; e_d = 32'd0;
            if (m_wbw()) begin
                e_we = 1'b1; e_a = wb_rd; e_d = wb_data;
            end else if (m_head_v()) begin
                e_we = 1'b1; e_a = mq[0].rd; e_d = mq[0].data;
            end
            tests++; if ({rf_we, rf_waddr, rf_wdata} !== {e_we, e_a, e_d}) begin
                fails++; $display("FAIL rnd_port c%0d: got %b/%0d/%h want %b/%0d/%h", cyc, rf_we, rf_waddr, rf_wdata, e_we, e_a, e_d);
            end
            tests++; if (lu_ready !== (mq.size() < DEPTH)) begin
                fails++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, lu_ready, mq.size() < DEPTH);
            end
            tests++; if ({pend_hit1, pend_hit2} !== {m_hit(rs1_q), m_hit(rs2_q)}) begin
                fails++; $display("FAIL rnd_hit c%0d: got %b%b want %b%b", cyc, pend_hit1, pend_hit2, m_hit(rs1_q), m_hit(rs2_q));
            end
            tests++; if (stall_req !== m_stall) begin
                fails++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, stall_req, m_stall);
            end
            tests++; if (pending_count !== 3'(mq.size())) begin
                fails++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, pending_count, mq.size());
            end
            tests++; if (rf_we && (rf_waddr == 5'd0)) begin
                fails++; $display("FAIL rnd_x0_write c%0d: got addr 0 want nonzero", cyc);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        model_clear();
        test_reset();
        test_basic();
        test_fill_drain();
        test_squash();
        test_x0();
        test_starve();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between the pipeline writeback stage and a long-latency result source (multi-cycle mul/div or load unit). Writeback always wins. Long-latency results wait in a small in-order buffer and drain on idle write-port cycles. Also provides pending-write lookups for the hazard unit and a stall request that stops the long-latency source from being starved.

Parameters:
DEPTH, 4, number of long-latency result buffer entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive blocked cycles before stall_req asserts (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
wb_valid  in  1  pipeline writeback requests a write this cycle
wb_rd  in  5  writeback destination register
wb_data  in  32  writeback data
lu_valid  in  1  long-latency unit offers a result
lu_rd  in  5  long-latency destination register
lu_data  in  32  long-latency result
lu_ready  out  1  buffer can accept a result this cycle
rs1_q  in  5  hazard query address 1
rs2_q  in  5  hazard query address 2
pend_hit1  out  1  a valid buffered entry targets rs1_q
pend_hit2  out  1  a valid buffered entry targets rs2_q
rf_we  out  1  register file write enable (RegWrite)
rf_waddr  out  5  register file write address
rf_wdata  out  32  register file write data
stall_req  out  1  registered request for the pipeline to insert a writeback bubble
pending_count  out  log2(DEPTH)+1  occupied buffer entries, including squashed ones

Behaviour:
- Reset (asynchronous): buffer empty, all entry valid bits 0, starve counter 0, stall_req 0, pending_count 0. While reset is high: rf_we=0, lu_ready=0, pend_hit1/2=0.
- Buffer: circular FIFO with head/tail pointers that wrap modulo DEPTH. Each entry holds rd, data and a valid bit.
- Accept:
  - lu_ready = (pending_count < DEPTH). Combinational from registered state only; it never depends on lu_valid.
  - A result is accepted when lu_valid && lu_ready.
  - lu_rd==0: accepted and discarded; not stored, count unchanged.
- Write-port selection (combinational, zero latency):
  - wb_valid && wb_rd!=0: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data.
  - Else, if the head entry is valid: rf_we=1, rf_waddr/rf_wdata from the head; head pops.
  - Else, if the head is an invalid (squashed) entry: rf_we=0; head pops.
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
- Squash (WAW ordering, writeback is younger):
  - When writeback writes rd!=0, every valid buffered entry with the same rd is invalidated at the clock edge.
  - A result accepted in the same cycle with the same rd is stored as invalid.
- Simultaneous accept and pop in one cycle is legal; pending_count stays unchanged.
- When full, a pop frees a slot only on the next cycle, because lu_ready uses registered count.
- pend_hit1/2: OR over valid entries of (entry.rd==rs_q && rs_q!=0). Combinational; reflects state before this cycle's edge.
- Starvation:
  - Counter increments each cycle the head is valid and is blocked by a writeback with wb_rd!=0.
  - Counter clears on any head pop, or when the buffer becomes empty.
  - stall_req is set at the edge where the counter reaches STARVE_LIMIT.
  - stall_req clears on the edge after the head pops.
  - The pipeline responds with wb_valid=0 on the following cycle. The arbiter does not depend on this for correctness.
- Invariants:
  - Ordering is strict FIFO.
  - No write to x0 is ever issued: rf_we=1 implies rf_waddr!=0.
  - Exactly one source drives the write port per cycle.

Test Plan:
1. Reset, then lu_valid with rd=5, data=0xDEAD_BEEF, wb idle -> lu_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; pending_count returns to 0.
2. wb_valid every cycle with rd=3, plus 4 lu results (rd=6..9) -> lu_ready=0 after the 4th accept; the 5th lu_valid is held off; after wb drops, rf writes 6,7,8,9 in order on consecutive cycles.
3. Buffer entry rd=10, then wb writes rd=10 data=0x1 -> entry squashed; pend_hit1 with rs1_q=10 goes 1 then 0; rf never receives the old rd=10 data; head pops with rf_we=0.
4. lu_rd=0 accepted -> nothing stored, rf_we stays 0, pending_count 0. Query rs1_q=0 -> pend_hit1=0.
5. Head valid, wb_valid with rd!=0 held 8 cycles, STARVE_LIMIT=8 -> stall_req rises after the 8th blocked cycle; wb released -> head writes; stall_req falls the next cycle.
6. Assert reset mid-drain with 3 entries pending -> rf_we, lu_ready and stall_req go 0 immediately; after release pending_count=0 and no stale write occurs.
